// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - fetch-to-decode instruction FIFO; optional same-cycle bypass under INST_QUEUE_BYPASS_EN
module inst_queue #(
  parameter int DEPTH       = 16,
  parameter int PTR_WIDTH   = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        IF_input_valid,
  input  logic [31:0] IF_inst,
  input  logic [31:0] IF_inst_pc,
  input  logic        IF_predicted_to_jump,
  input  logic [31:0] IF_predicted_pc,
  output logic        IF_is_full,
  input  logic        DEC_ready,
  output logic        DEC_output_valid,
  output logic [31:0] DEC_inst,
  output logic [31:0] DEC_inst_pc,
  output logic        DEC_predicted_to_jump,
  output logic [31:0] DEC_predicted_pc,
  input  logic        ROB_roll_back_flag,
  output logic        overflow
);

  // count is one bit wider than the pointers so that "full" (DEPTH) is representable
  localparam logic [PTR_WIDTH:0] DEPTH_C     = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] FULL_THRESH = (PTR_WIDTH+1)'(DEPTH - FULL_MARGIN);

  logic [31:0]          inst_mem_q [DEPTH];
  logic [31:0]          pc_mem_q   [DEPTH];
  logic                 jump_mem_q [DEPTH];
  logic [31:0]          pred_mem_q [DEPTH];

  logic [PTR_WIDTH-1:0] head_q, head_d;
  logic [PTR_WIDTH-1:0] tail_q, tail_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;

  logic head_valid;
  logic bypass;
  logic byp_take;
  logic deq;
  logic enq;
  logic drop;

  // A roll back masks the head entry in the very cycle it is requested
  assign head_valid = (count_q != '0) && !ROB_roll_back_flag;

`ifdef INST_QUEUE_BYPASS_EN
  // Empty queue: hand the incoming instruction straight to the decoder
  assign bypass = (count_q == '0) && IF_input_valid && !ROB_roll_back_flag;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed instruction the decoder accepts never touches storage
  assign byp_take = bypass && DEC_ready;
  assign deq      = head_valid && DEC_ready;
  // When full, a same-cycle dequeue frees the slot being written
  assign enq      = IF_input_valid && !ROB_roll_back_flag && !byp_take &&
                    ((count_q != DEPTH_C) || deq);
  assign drop     = IF_input_valid && !ROB_roll_back_flag &&
                    (count_q == DEPTH_C) && !deq;

  assign DEC_output_valid      = head_valid || bypass;
  assign DEC_inst              = bypass ? IF_inst              : inst_mem_q[head_q];
  assign DEC_inst_pc           = bypass ? IF_inst_pc           : pc_mem_q[head_q];
  assign DEC_predicted_to_jump = bypass ? IF_predicted_to_jump : jump_mem_q[head_q];
  assign DEC_predicted_pc      = bypass ? IF_predicted_pc      : pred_mem_q[head_q];

  // Margin leaves room for the instruction already in flight from the fetcher
  assign IF_is_full = (count_q >= FULL_THRESH);
  assign overflow   = overflow_q;

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (rdy) begin
      if (ROB_roll_back_flag) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (deq) head_d = head_q + PTR_WIDTH'(1);
        if (enq) tail_d = tail_q + PTR_WIDTH'(1);
        case ({enq, deq})
          2'b10:   count_d = count_q + (PTR_WIDTH+1)'(1);
          2'b01:   count_d = count_q - (PTR_WIDTH+1)'(1);
          default: count_d = count_q;
        endcase
        if (drop) overflow_d = 1'b1;
      end
    end
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage, written at the tail; deliberately not reset
  always_ff @(posedge clk) begin
    if (rdy && enq) begin
      inst_mem_q[tail_q] <= IF_inst;
      pc_mem_q[tail_q]   <= IF_inst_pc;
      jump_mem_q[tail_q] <= IF_predicted_to_jump;
      pred_mem_q[tail_q] <= IF_predicted_pc;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed self-checking bench for inst_queue
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        IF_input_valid;
  logic [31:0] IF_inst;
  logic [31:0] IF_inst_pc;
  logic        IF_predicted_to_jump;
  logic [31:0] IF_predicted_pc;
  logic        IF_is_full;
  logic        DEC_ready;
  logic        DEC_output_valid;
  logic [31:0] DEC_inst;
  logic [31:0] DEC_inst_pc;
  logic        DEC_predicted_to_jump;
  logic [31:0] DEC_predicted_pc;
  logic        ROB_roll_back_flag;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  inst_queue dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rdy                  (rdy),
    .IF_input_valid       (IF_input_valid),
    .IF_inst              (IF_inst),
    .IF_inst_pc           (IF_inst_pc),
    .IF_predicted_to_jump (IF_predicted_to_jump),
    .IF_predicted_pc      (IF_predicted_pc),
    .IF_is_full           (IF_is_full),
    .DEC_ready            (DEC_ready),
    .DEC_output_valid     (DEC_output_valid),
    .DEC_inst             (DEC_inst),
    .DEC_inst_pc          (DEC_inst_pc),
    .DEC_predicted_to_jump(DEC_predicted_to_jump),
    .DEC_predicted_pc     (DEC_predicted_pc),
    .ROB_roll_back_flag   (ROB_roll_back_flag),
    .overflow             (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    rdy                  = 1'b1;
    IF_input_valid       = 1'b0;
    IF_inst              = 32'h0;
    IF_inst_pc           = 32'h0;
    IF_predicted_to_jump = 1'b0;
    IF_predicted_pc      = 32'h0;
    DEC_ready            = 1'b0;
    ROB_roll_back_flag   = 1'b0;
  endtask

  task automatic drive_if(input logic [31:0] inst, input logic [31:0] pc,
                          input logic jmp, input logic [31:0] pp);
    IF_input_valid       = 1'b1;
    IF_inst              = inst;
    IF_inst_pc           = pc;
    IF_predicted_to_jump = jmp;
    IF_predicted_pc      = pp;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Enqueue n entries with DEC_ready low; pc = base + 4*i, inst = 0x100 + i
  task automatic enqueue_n(input logic [31:0] base, input int n);
    DEC_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_if(32'h100 + 32'(i), base + 32'(4 * i), 1'b0, base + 32'(4 * i) + 32'h4);
    end
    @(negedge clk);
    IF_input_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (DEC_output_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", DEC_output_valid);
    end
    n_tests++;
    if (IF_is_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_full: got %b expected 0", IF_is_full);
    end
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_pass();
    do_reset();
    @(negedge clk);
    drive_if(32'h00000013, 32'h0, 1'b0, 32'h4);
`ifdef INST_QUEUE_BYPASS_EN
    DEC_ready = 1'b0;
`else
    DEC_ready = 1'b1;
`endif
    @(negedge clk);
    IF_input_valid = 1'b0;
    DEC_ready      = 1'b1;
    #1;
    n_tests++;
    if (DEC_output_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_valid: got %b expected 1", DEC_output_valid);
    end
    n_tests++;
    if (DEC_inst !== 32'h00000013) begin
      n_fail++; $display("FAIL single_inst: got %h expected 00000013", DEC_inst);
    end
    n_tests++;
    if (DEC_inst_pc !== 32'h0) begin
      n_fail++; $display("FAIL single_pc: got %h expected 00000000", DEC_inst_pc);
    end
    n_tests++;
    if (DEC_predicted_to_jump !== 1'b0) begin
      n_fail++; $display("FAIL single_jump: got %b expected 0", DEC_predicted_to_jump);
    end
    n_tests++;
    if (DEC_predicted_pc !== 32'h4) begin
      n_fail++; $display("FAIL single_pred: got %h expected 00000004", DEC_predicted_pc);
    end
    @(negedge clk);
    DEC_ready = 1'b0;
    #1;
    n_tests++;
    if (DEC_output_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_empty_after: got %b expected 0", DEC_output_valid);
    end
  endtask

  task automatic test_fill_full();
    do_reset();
    DEC_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive_if(32'h100 + 32'(i), 32'(4 * i), 1'b0, 32'h0);
      #1;
      n_tests++;
      if (IF_is_full !== (i >= 14)) begin
        n_fail++; $display("FAIL fill_full_at_count%0d: got %b expected %b", i, IF_is_full, (i >= 14));
      end
    end
    @(negedge clk);
    drive_if(32'hDEAD_BEEF, 32'hDEAD, 1'b1, 32'h0);
    #1;
    n_tests++;
    if (overflow !== 1'b0 || IF_is_full !== 1'b1) begin
      n_fail++; $display("FAIL fill_at16: got ovf=%b full=%b expected ovf=0 full=1", overflow, IF_is_full);
    end
    @(negedge clk);
    IF_input_valid = 1'b0;
    #1;
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL fill_overflow: got %b expected 1", overflow);
    end
    n_tests++;
    if (DEC_inst_pc !== 32'h0 || DEC_inst !== 32'h100) begin
      n_fail++; $display("FAIL fill_head: got pc=%h inst=%h expected pc=0 inst=100", DEC_inst_pc, DEC_inst);
    end
    DEC_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_tests++;
      if (DEC_output_valid !== 1'b1 || DEC_inst_pc !== 32'(4 * i)) begin
        n_fail++; $display("FAIL fill_drain%0d: got v=%b pc=%h expected v=1 pc=%h", i, DEC_output_valid, DEC_inst_pc, 32'(4 * i));
      end
      @(negedge clk);
    end
    #1;
    n_tests++;
    if (DEC_output_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL fill_drained: got v=%b ovf=%b expected v=0 ovf=1", DEC_output_valid, overflow);
    end
    DEC_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_overflow: got %b expected 0", overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    int sent;
    int got;
    int cyc;
    do_reset();
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 40 && cyc < 400) begin
      @(negedge clk);
      DEC_ready = (cyc % 2 == 0);
      if (sent < 40 && !IF_is_full && (cyc % 3 != 2)) begin
        drive_if(32'h1000 + 32'(sent), 32'(4 * sent), sent[0], 32'(4 * sent) + 32'h8);
        sent++;
      end else begin
        IF_input_valid = 1'b0;
      end
      #1;
      if (DEC_output_valid && DEC_ready) begin
        n_tests++;
        if (DEC_inst_pc !== 32'(4 * got) || DEC_inst !== 32'h1000 + 32'(got)) begin
          n_fail++; $display("FAIL wrap_seq%0d: got pc=%h inst=%h expected pc=%h inst=%h", got, DEC_inst_pc, DEC_inst, 32'(4 * got), 32'h1000 + 32'(got));
        end
        got++;
      end
      cyc++;
    end
    n_tests++;
    if (got != 40) begin
      n_fail++; $display("FAIL wrap_count: got %0d entries expected 40", got);
    end
    @(negedge clk);
    IF_input_valid = 1'b0;
    DEC_ready      = 1'b0;
    #1;
    n_tests++;
    if (DEC_output_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL wrap_tail: got v=%b ovf=%b expected v=0 ovf=0", DEC_output_valid, overflow);
    end
  endtask

  task automatic test_roll_back();
    do_reset();
    enqueue_n(32'h200, 5);
    @(negedge clk);
    drive_if(32'h333, 32'h300, 1'b0, 32'h304);
    ROB_roll_back_flag = 1'b1;
    DEC_ready          = 1'b1;
    #1;
    n_tests++;
    if (DEC_output_valid !== 1'b0) begin
      n_fail++; $display("FAIL rb_valid_during: got %b expected 0", DEC_output_valid);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_tests++;
    if (DEC_output_valid !== 1'b0 || IF_is_full !== 1'b0) begin
      n_fail++; $display("FAIL rb_empty_after: got v=%b full=%b expected v=0 full=0", DEC_output_valid, IF_is_full);
    end
    enqueue_n(32'h400, 1);
    #1;
    n_tests++;
    if (DEC_output_valid !== 1'b1 || DEC_inst_pc !== 32'h400) begin
      n_fail++; $display("FAIL rb_restart: got v=%b pc=%h expected v=1 pc=00000400", DEC_output_valid, DEC_inst_pc);
    end
  endtask

  task automatic test_rdy_freeze();
    do_reset();
    enqueue_n(32'h500, 3);
    @(negedge clk);
    rdy = 1'b0;
    drive_if(32'h666, 32'h600, 1'b0, 32'h604);
    DEC_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_tests++;
      if (DEC_output_valid !== 1'b1 || DEC_inst_pc !== 32'h500) begin
        n_fail++; $display("FAIL freeze_head%0d: got v=%b pc=%h expected v=1 pc=00000500", c, DEC_output_valid, DEC_inst_pc);
      end
      @(negedge clk);
    end
    rdy            = 1'b1;
    IF_input_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (DEC_output_valid !== 1'b1 || DEC_inst_pc !== 32'h500 + 32'(4 * i)) begin
        n_fail++; $display("FAIL freeze_drain%0d: got v=%b pc=%h expected v=1 pc=%h", i, DEC_output_valid, DEC_inst_pc, 32'h500 + 32'(4 * i));
      end
      @(negedge clk);
    end
    #1;
    n_tests++;
    if (DEC_output_valid !== 1'b0) begin
      n_fail++; $display("FAIL freeze_count3: got %b expected 0", DEC_output_valid);
    end
    DEC_ready = 1'b0;
  endtask

  task automatic test_bypass();
    do_reset();
    @(negedge clk);
    drive_if(32'h77, 32'h700, 1'b1, 32'h800);
    DEC_ready = 1'b1;
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    n_tests++;
    if (DEC_output_valid !== 1'b1 || DEC_inst !== 32'h77 || DEC_inst_pc !== 32'h700) begin
      n_fail++; $display("FAIL bypass_same_cycle: got v=%b inst=%h pc=%h expected v=1 inst=77 pc=700", DEC_output_valid, DEC_inst, DEC_inst_pc);
    end
`else
    n_tests++;
    if (DEC_output_valid !== 1'b0) begin
      n_fail++; $display("FAIL nobypass_same_cycle: got %b expected 0", DEC_output_valid);
    end
`endif
    @(negedge clk);
    idle_inputs();
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    n_tests++;
    if (DEC_output_valid !== 1'b0) begin
      n_fail++; $display("FAIL bypass_count0: got %b expected 0", DEC_output_valid);
    end
`else
    n_tests++;
    if (DEC_output_valid !== 1'b1 || DEC_inst_pc !== 32'h700 || DEC_predicted_to_jump !== 1'b1) begin
      n_fail++; $display("FAIL nobypass_next_cycle: got v=%b pc=%h j=%b expected v=1 pc=700 j=1", DEC_output_valid, DEC_inst_pc, DEC_predicted_to_jump);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_fill_full();
    test_wrap();
    test_roll_back();
    test_rdy_freeze();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
